// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit machine word and the PC-control FSM states.
// Also holds the helper that word-aligns redirect targets.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } pcctl_state_t;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_ctrl.sv
// PC next-value control: picks sequential, redirect or held PC, buffers a
// redirect that lands while imem is still busy, and stops fetch on halt.
module pc_next_ctrl
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter word_t PC_STEP  = 32'd4
) (
    input  logic  CLK,
    input  logic  RST,
    input  word_t pcout,
    input  logic  ihit,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_tgt,
    input  logic  halt,
    output logic  pcenable,
    output word_t pcnext,
    output logic  iREN,
    output logic  redirect_busy
);

    pcctl_state_t state_reg, state_next;
    word_t        pend_reg, pend_next;
    word_t        seq_pc;
    word_t        tgt;

    assign seq_pc = pcout + PC_STEP;
    assign tgt    = word_align(redirect_tgt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= RUN;
            pend_reg  <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pend_next     = pend_reg;
        pcenable      = 1'b0;
        pcnext        = seq_pc;
        iREN          = 1'b1;
        redirect_busy = 1'b0;

        // Reset is asynchronous, so outputs must follow RST between edges too.
        if (RST) begin
            pcnext = RESET_PC;
            iREN   = 1'b0;
        end else begin
            unique case (state_reg)
                RUN, PEND: begin
                    redirect_busy = (state_reg == PEND);
                    if (halt) begin
                        state_next = HALTED;
                        pend_next  = RESET_PC;
                        pcnext     = RESET_PC;
                    end else if (redirect) begin
                        // A fresh redirect always supersedes any buffered target.
                        pcnext = tgt;
                        if (ihit) begin
                            pcenable   = 1'b1;
                            state_next = RUN;
                        end else begin
                            pend_next  = tgt;
                            state_next = PEND;
                        end
                    end else if (state_reg == PEND) begin
                        pcnext = pend_reg;
                        if (ihit) begin
                            pcenable   = 1'b1;
                            state_next = RUN;
                        end
                    end else if (ihit && !stall) begin
                        pcenable = 1'b1;
                    end
                end
                HALTED: begin
                    iREN   = 1'b0;
                    pcnext = RESET_PC;
                end
                default: begin
                    state_next = RUN;
                    pend_next  = RESET_PC;
                    iREN       = 1'b0;
                    pcnext     = RESET_PC;
                end
            endcase
        end
    end

endmodule
